// File: rtl/lut_scheduler.sv
// 16x1 lookup table with a power-up INIT sweep, a config write port and two
// round-robin lookup requesters; config writes win unless a write burst starves lookups.
module lut_scheduler #(
  parameter logic [15:0] INIT_VAL  = 16'h0000,
  parameter int unsigned CFG_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [3:0] cfg_addr,
  input  logic       cfg_data,
  output logic       cfg_ready,
  input  logic       req0,
  input  logic [3:0] addr0,
  input  logic       req1,
  input  logic [3:0] addr1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic       rdata,
  output logic       init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  burst_q, burst_d;
  logic        prio1_q, prio1_d;
  logic        rdata_q, rdata_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [15:0] lut_q, lut_d;

  logic run;
  logic any_req;
  logic starve;
  logic cfg_acc;

  // Handshakes: cfg_ready/gnt0/gnt1 are one-hot-or-zero and combinational;
  // a transfer happens on the rising edge where cfg_we&cfg_ready or gntN is high.
  // cfg_ready also rises when nothing is requested, which is a harmless no-op.
  always_comb begin
    run       = (state_q == ST_RUN);
    any_req   = req0 | req1;
    starve    = (burst_q == 3'(CFG_BURST)) && any_req;
    cfg_ready = run && !starve && (cfg_we || !any_req);
    cfg_acc   = cfg_ready && cfg_we;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (run && !cfg_ready && any_req) begin
      if (req0 && req1) begin
        gnt0 = !prio1_q;
        gnt1 = prio1_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    burst_d   = 3'd0;
    prio1_d   = prio1_q;
    rdata_d   = rdata_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    lut_d     = lut_q;
    case (state_q)
      ST_INIT: begin
        lut_d[cnt_q] = INIT_VAL[cnt_q];
        cnt_d        = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cfg_acc) begin
          lut_d[cfg_addr] = cfg_data;
          burst_d = (burst_q == 3'd7) ? burst_q : burst_q + 3'd1;
        end
        if (gnt0) begin
          rdata_d   = lut_q[addr0];
          rvalid0_d = 1'b1;
          prio1_d   = 1'b1;
        end else if (gnt1) begin
          rdata_d   = lut_q[addr1];
          rvalid1_d = 1'b1;
          prio1_d   = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= 4'd0;
      burst_q   <= 3'd0;
      prio1_q   <= 1'b0;
      rdata_q   <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      prio1_q   <= prio1_d;
      rdata_q   <= rdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Storage is deliberately not reset; the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    lut_q <= lut_d;
  end

  assign rdata     = rdata_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign init_done = run;

endmodule

// File: tb/tb_lut_scheduler.sv
// Bench for lut_scheduler: a cycle model predicts grants and read results,
// pushed to a scoreboard queue and popped when rvalid is due.
module tb_lut_scheduler;

  localparam logic [15:0] INIT_VAL  = 16'hA5C3;
  localparam int unsigned CFG_BURST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = 4'd0;
  logic       cfg_data = 1'b0;
  logic       cfg_ready;
  logic       req0 = 1'b0;
  logic [3:0] addr0 = 4'd0;
  logic       req1 = 1'b0;
  logic [3:0] addr1 = 4'd0;
  logic       gnt0, gnt1, rvalid0, rvalid1, rdata, init_done;

  int checks = 0;
  int errors = 0;

  // Model state.
  logic [15:0] m_lut;
  logic        m_prio1;
  int          m_burst;
  logic        m_rdata;
  logic [1:0]  exp_q[$];   // {requester id, data}

  lut_scheduler #(.INIT_VAL(INIT_VAL), .CFG_BURST(CFG_BURST)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_lut   = INIT_VAL;
    m_prio1 = 1'b0;
    m_burst = 0;
    m_rdata = 1'b0;
    exp_q.delete();
  endtask

  // One RUN cycle: inputs driven at negedge, combinational outputs checked,
  // then the registered result checked just after the rising edge.
  task automatic do_cycle(input logic we, input logic [3:0] ca, input logic cd,
                          input logic r0, input logic [3:0] a0,
                          input logic r1, input logic [3:0] a1);
    logic any, starve, e_cfg, e_g0, e_g1;
    logic [1:0] e;
    cfg_we = we; cfg_addr = ca; cfg_data = cd;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #1;
    any    = r0 | r1;
    starve = (m_burst == CFG_BURST) && any;
    e_cfg  = !starve && (we || !any);
    e_g0   = 1'b0;
    e_g1   = 1'b0;
    if (!e_cfg && any) begin
      if (r0 && r1) begin
        e_g0 = !m_prio1; e_g1 = m_prio1;
      end else begin
        e_g0 = r0; e_g1 = r1;
      end
    end
    checks++;
    if ({cfg_ready, gnt0, gnt1} !== {e_cfg, e_g0, e_g1}) begin
      errors++;
      $display("FAIL handshake t=%0t {cfg_ready,gnt0,gnt1} got %b exp %b", $time,
               {cfg_ready, gnt0, gnt1}, {e_cfg, e_g0, e_g1});
    end
    if (e_g0) exp_q.push_back({1'b0, m_lut[a0]});
    if (e_g1) exp_q.push_back({1'b1, m_lut[a1]});
    @(posedge clk); #1;
    if (e_cfg && we) begin
      m_lut[ca] = cd;
      if (m_burst < 7) m_burst++;
    end else begin
      m_burst = 0;
    end
    if (e_g0) m_prio1 = 1'b1;
    if (e_g1) m_prio1 = 1'b0;
    checks++;
    if (e_g0 || e_g1) begin
      e = exp_q.pop_front();
      m_rdata = e[0];
      if ({rvalid0, rvalid1, rdata} !== {!e[1], e[1], e[0]}) begin
        errors++;
        $display("FAIL read_result t=%0t {rv0,rv1,rdata} got %b exp %b", $time,
                 {rvalid0, rvalid1, rdata}, {!e[1], e[1], e[0]});
      end
    end else if ({rvalid0, rvalid1, rdata} !== {2'b00, m_rdata}) begin
      errors++;
      $display("FAIL idle_hold t=%0t {rv0,rv1,rdata} got %b exp %b", $time,
               {rvalid0, rvalid1, rdata}, {2'b00, m_rdata});
    end
    @(negedge clk);
  endtask

  // Called at a negedge right after rst is released, with req0/cfg_we held.
  task automatic wait_init();
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if ({init_done, gnt0, gnt1, cfg_ready, rvalid0, rvalid1} !== 6'b0) begin
        errors++;
        $display("FAIL init_quiet cycle %0d outputs got %b exp 000000", i,
                 {init_done, gnt0, gnt1, cfg_ready, rvalid0, rvalid1});
      end
      @(negedge clk);
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done_rise got %b exp 1", init_done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({gnt0, gnt1, cfg_ready, init_done, rvalid0, rvalid1, rdata} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000000",
               {gnt0, gnt1, cfg_ready, init_done, rvalid0, rvalid1, rdata});
    end
  endtask

  task automatic test_init();
    @(negedge clk);
    req0 = 1'b1; addr0 = 4'd0; cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 1'b0;
    rst = 1'b0;
    model_reset();
    wait_init();
  endtask

  task automatic test_lookup_all();
    for (int a = 0; a < 16; a++) do_cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'(a), 1'b0, 4'd0);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 4'd2);
  endtask

  task automatic test_cfg_raw();
    do_cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    do_cycle(1'b1, 4'hA, 1'b1, 1'b1, 4'hA, 1'b0, 4'd0);
    do_cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'hA, 1'b0, 4'd0);
    checks++;
    if (m_rdata !== 1'b1 || rdata !== 1'b1) begin
      errors++;
      $display("FAIL raw_value got %b exp 1", rdata);
    end
  endtask

  task automatic test_starvation();
    do_cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) do_cycle(1'b1, 4'(i), 1'b1, 1'b0, 4'd0, 1'b1, 4'd5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++)
      do_cycle(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
  endtask

  task automatic test_reset_mid_run();
    do_cycle(1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);  // INIT_VAL[1] is 1; write 1 then 0
    do_cycle(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    cfg_we = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 4'd0; addr1 = 4'd1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, cfg_ready, init_done, rvalid0, rvalid1, rdata} !== 7'b0) begin
      errors++;
      $display("FAIL reset_async got %b exp 0000000",
               {gnt0, gnt1, cfg_ready, init_done, rvalid0, rvalid1, rdata});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_init();
    do_cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0);
    checks++;
    if (rdata !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_entry1 got %b exp 1", rdata);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init();
    test_lookup_all();
    test_round_robin();
    test_cfg_raw();
    test_starvation();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_scheduler.md
LUT_SCHEDULER -- requirements
Module: lut_scheduler

Interface
REQ-001 SHALL have parameter INIT_VAL, default 16'h0000: LUT contents loaded after reset; bit i is entry i.
REQ-002 SHALL have parameter CFG_BURST, default 4: maximum consecutive accepted config writes while a lookup is pending.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have these ports, clock and reset first:
- clk  input  1: clock; all state updates on its rising edge.
- rst  input  1: asynchronous, active-high reset.
- cfg_we  input  1: config write request.
- cfg_addr  input  4: config write entry.
- cfg_data  input  1: config write value.
- cfg_ready  output  1: config write accepted this cycle when high with cfg_we.
- req0  input  1: lookup request, requester 0.
- addr0  input  4: lookup address, requester 0.
- req1  input  1: lookup request, requester 1.
- addr1  input  4: lookup address, requester 1.
- gnt0  output  1: requester 0 lookup accepted this cycle.
- gnt1  output  1: requester 1 lookup accepted this cycle.
- rvalid0  output  1: rdata belongs to requester 0.
- rvalid1  output  1: rdata belongs to requester 1.
- rdata  output  1: lookup result.
- init_done  output  1: INIT complete, block in RUN.

Function
REQ-005 SHALL hold a 16x1 LUT storage array internally, written only by the INIT sequence or accepted config writes.
REQ-006 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-007 In INIT: 4-bit counter from 0; each cycle write INIT_VAL[cnt] to entry cnt; cnt increments; after writing entry 15, next state RUN. INIT lasts exactly 16 cycles.
REQ-008 In INIT: gnt0, gnt1, cfg_ready, init_done SHALL be 0; req and cfg inputs ignored, not queued.
REQ-009 In RUN: init_done = 1; state never leaves RUN except by reset.
REQ-010 gnt0, gnt1, cfg_ready SHALL be combinational on current-cycle inputs and state; at most one of them is high per cycle.
REQ-011 Priority in RUN: cfg write over lookups, unless the starvation rule (REQ-014) blocks it.
REQ-012 Accepted config write (cfg_we & cfg_ready) updates entry cfg_addr with cfg_data at the clock edge; no lookup granted that cycle.
REQ-013 Lookup arbitration: only one req high -> grant it; both high -> round-robin; grant the requester not granted most recently. After reset, requester 0 has priority.
REQ-014 Starvation: a 3-bit counter counts consecutive accepted config writes; it clears on any cycle without an accepted write. When count == CFG_BURST and (req0 | req1), cfg_ready = 0 for that cycle and a lookup is granted.
REQ-015 Granted lookup: at next edge, rdata <= LUT[addr of granted requester] and the matching rvalid goes 1 for exactly one cycle. Latency is one cycle from grant.
REQ-016 No grant this cycle -> rvalid0 = rvalid1 = 0 next cycle; rdata holds its last value.
REQ-017 Read-after-write: a lookup granted in the cycle after a config write to the same entry returns the new value.
REQ-018 cfg_ready = 1 in RUN whenever REQ-014 does not block; with cfg_we = 0 the acceptance is a no-op.

Reset
REQ-019 On rst high, asynchronously, SHALL set: state INIT, INIT counter 0, burst counter 0, round-robin pointer to favour requester 0, gnt0/gnt1/cfg_ready/init_done/rvalid0/rvalid1/rdata = 0.
REQ-020 Reset asserted mid-INIT or mid-RUN SHALL restart the full 16-cycle INIT; LUT storage is not cleared by rst itself, only overwritten by INIT.

Verification
REQ-021 INIT: INIT_VAL=16'hA5C3, release rst, hold req0 -> no grant for 16 cycles, init_done rises cycle 16; lookups of addr 0..15 return bits of A5C3 (addr0=0 -> 1, addr0=2 -> 0).
REQ-022 Round-robin: req0 and req1 held high, addr0=1, addr1=2 -> grants alternate gnt0, gnt1, gnt0...; rvalid0/rvalid1 alternate one cycle later with correct data.
REQ-023 Config priority and RAW: cfg_we addr 4'hA data 1 with req0 addr 4'hA same cycle -> cfg_ready=1, gnt0=0; next cycle gnt0=1; following cycle rdata=1, rvalid0=1.
REQ-024 Starvation: cfg_we held high for 6 cycles, req1 held high -> 4 writes accepted, cycle 5 gnt1=1 and cfg_ready=0, cycle 6 write accepted.
REQ-025 Reset mid-RUN: assert rst during active lookups -> all outputs 0 immediately; init_done stays 0 for 16 cycles after release; entry written by config before reset reads INIT_VAL value afterwards.
